lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: turns one decoded load or store into a
// single word-aligned memory request and returns sign- or zero-extended load data.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_is_load,
  input  logic        op_zero_ext,
  input  logic [1:0]  op_size,
  input  logic [4:0]  op_rd,
  input  logic [31:0] op_base,
  input  logic [11:0] op_imm,
  input  logic [31:0] op_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_WB} state_t;

  state_t      state_q;
  logic        op_ready_q;
  logic        mem_req_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        misalign_q;

  // Op fields kept for the load-return path; captured only on accept.
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic [4:0]  rd_q;

  logic [31:0] ea_d;
  logic        misal_d;
  logic        accept_d;

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << {off[1], 1'b0};
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      2'd0:    store_data = {4{wdata[7:0]}};
      2'd1:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic zext);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = rdata >> {off, 3'b000};
    h_sh = rdata >> {off[1], 4'b0000};
    case (size)
      2'd0:    load_ext = zext ? {24'd0, b_sh[7:0]}  : {{24{b_sh[7]}}, b_sh[7:0]};
      2'd1:    load_ext = zext ? {16'd0, h_sh[15:0]} : {{16{h_sh[15]}}, h_sh[15:0]};
      default: load_ext = rdata;
    endcase
  endfunction

  always_comb begin
    ea_d     = op_base + {{20{op_imm[11]}}, op_imm};
    misal_d  = is_misaligned(ea_d[1:0], op_size);
    accept_d = op_valid && op_ready_q;
  end

  always_ff @(posedge clk) begin
    if (accept_d) begin
      off_q  <= ea_d[1:0];
      size_q <= op_size;
      zext_q <= op_zero_ext;
      rd_q   <= op_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      op_ready_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= '0;
      mem_wdata_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      misalign_q      <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          op_ready_q <= 1'b1;
          if (accept_d) begin
            if (misal_d) begin
              misalign_q <= 1'b1;
            end else begin
              state_q         <= S_REQ;
              op_ready_q      <= 1'b0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {ea_d[31:2], 2'b00};
              mem_we_q        <= !op_is_load;
              mem_be_q        <= lane_mask(ea_d[1:0], op_size);
              mem_wdata_q     <= op_is_load ? 32'd0 : store_data(op_wdata, op_size);
            end
          end
        end
        // Request outputs are only touched on the handshake, so they hold under backpressure.
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            if (mem_we_q) begin
              state_q    <= S_IDLE;
              op_ready_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            state_q <= S_WB;
            if (rd_q != 5'd0) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_ext(mem_rdata, off_q, size_q, zext_q);
            end
          end
        end
        S_WB: begin
          state_q    <= S_IDLE;
          op_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_ready      = op_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic        op_is_load;
  logic        op_zero_ext;
  logic [1:0]  op_size;
  logic [4:0]  op_rd;
  logic [31:0] op_base;
  logic [11:0] op_imm;
  logic [31:0] op_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int checks;
  int failures;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_load(op_is_load),
    .op_zero_ext(op_zero_ext), .op_size(op_size), .op_rd(op_rd),
    .op_base(op_base), .op_imm(op_imm), .op_wdata(op_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic is_load, input logic zext, input logic [1:0] size,
                          input logic [4:0] rd, input logic [31:0] base,
                          input logic [11:0] imm, input logic [31:0] wdata);
    op_valid    = 1'b1;
    op_is_load  = is_load;
    op_zero_ext = zext;
    op_size     = size;
    op_rd       = rd;
    op_base     = base;
    op_imm      = imm;
    op_wdata    = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata, wb_valid, wb_rd,
         wb_data, misalign} !== 110'd0) begin
      failures++;
      $display("FAIL reset_outputs: op_ready=%b req=%b addr=%h wb_valid=%b wb_data=%h required all 0",
               op_ready, mem_req_valid, mem_addr, wb_valid, wb_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: op_ready=%b required 1", op_ready);
    end
  endtask

  task automatic test_lw();
    mem_req_ready = 1'b1;
    drive_op(1'b1, 1'b0, 2'd2, 5'd5, 32'h0000_1000, 12'h004, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if ({mem_req_valid, mem_we, mem_be, op_ready} !== {1'b1, 1'b0, 4'b1111, 1'b0} ||
        mem_addr !== 32'h0000_1004 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL lw_req: valid=%b we=%b be=%b ready=%b addr=%h wdata=%h required 1 0 1111 0 00001004 00000000",
               mem_req_valid, mem_we, mem_be, op_ready, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({mem_req_valid, wb_valid} !== 2'b00) begin
      failures++;
      $display("FAIL lw_wait: req=%b wb_valid=%b required 0 0", mem_req_valid, wb_valid);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lw_wb: wb_valid=%b rd=%0d data=%h required 1 5 deadbeef", wb_valid, wb_rd, wb_data);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF || op_ready !== 1'b1) begin
      failures++;
      $display("FAIL lw_hold: wb_valid=%b rd=%0d data=%h ready=%b required 0 5 deadbeef 1",
               wb_valid, wb_rd, wb_data, op_ready);
    end
  endtask

  task automatic test_lb(input logic zext, input logic [31:0] exp_data);
    mem_req_ready = 1'b1;
    drive_op(1'b1, zext, 2'd0, 5'd7, 32'h0000_2003, 12'h000, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h0000_2000 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL lb_req zext=%b: valid=%b be=%b addr=%h we=%b required 1 1000 00002000 0",
               zext, mem_req_valid, mem_be, mem_addr, mem_we);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h80FF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== exp_data) begin
      failures++;
      $display("FAIL lb_wb zext=%b: wb_valid=%b rd=%0d data=%h required 1 7 %h",
               zext, wb_valid, wb_rd, wb_data, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_sh();
    mem_req_ready = 1'b1;
    drive_op(1'b0, 1'b0, 2'd1, 5'd3, 32'h0000_3000, 12'hFFE, 32'h1234_ABCD);
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_2FFC || mem_be !== 4'b1100 ||
        mem_wdata !== 32'hABCD_ABCD || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL sh_req: valid=%b addr=%h be=%b wdata=%h we=%b required 1 00002ffc 1100 abcdabcd 1",
               mem_req_valid, mem_addr, mem_be, mem_wdata, mem_we);
    end
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL sh_done: ready=%b req=%b wb_valid=%b required 1 0 0", op_ready, mem_req_valid, wb_valid);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL sh_no_wb: wb_valid=%b required 0", wb_valid);
    end
  endtask

  task automatic test_misalign();
    mem_req_ready = 1'b1;
    drive_op(1'b1, 1'b0, 2'd2, 5'd9, 32'h0000_1002, 12'h000, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (misalign !== 1'b1 || mem_req_valid !== 1'b0 || op_ready !== 1'b1) begin
      failures++;
      $display("FAIL misalign_pulse: misalign=%b req=%b ready=%b required 1 0 1", misalign, mem_req_valid, op_ready);
    end
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_end: misalign=%b req=%b wb_valid=%b required 0 0 0", misalign, mem_req_valid, wb_valid);
    end
  endtask

  task automatic test_backpressure();
    mem_req_ready = 1'b0;
    drive_op(1'b0, 1'b0, 2'd2, 5'd0, 32'h0000_4000, 12'h008, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_4008 || mem_be !== 4'b1111 ||
          mem_wdata !== 32'hCAFE_F00D || mem_we !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b addr=%h be=%b wdata=%h we=%b required 1 00004008 1111 cafef00d 1",
                 i, mem_req_valid, mem_addr, mem_be, mem_wdata, mem_we);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: ready=%b req=%b required 1 0", op_ready, mem_req_valid);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || op_ready !== 1'b1 || mem_req_valid !== 1'b0 || wb_data !== 32'h0000_0080) begin
        failures++;
        $display("FAIL idle_rsp_ignored[%0d]: wb_valid=%b ready=%b req=%b data=%h required 0 1 0 00000080",
                 i, wb_valid, op_ready, mem_req_valid, wb_data);
      end
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_rd_zero();
    mem_req_ready = 1'b1;
    drive_op(1'b1, 1'b0, 2'd2, 5'd0, 32'h0000_5000, 12'h000, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_5000) begin
      failures++;
      $display("FAIL rd0_req: valid=%b addr=%h required 1 00005000", mem_req_valid, mem_addr);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1111_1111;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0000_0080 || wb_rd !== 5'd7) begin
      failures++;
      $display("FAIL rd0_wb: wb_valid=%b data=%h rd=%0d required 0 00000080 7", wb_valid, wb_data, wb_rd);
    end
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_ready: ready=%b required 1", op_ready);
    end
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1'b1;
    drive_op(1'b1, 1'b0, 2'd2, 5'd12, 32'h0000_6000, 12'h000, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata, wb_valid, wb_rd,
         wb_data, misalign} !== 110'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ready=%b req=%b addr=%h wb_rd=%0d wb_data=%h required all 0",
               op_ready, mem_req_valid, mem_addr, wb_rd, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || op_ready !== 1'b1 || wb_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid_rsp[%0d]: wb_valid=%b ready=%b data=%h required 0 1 00000000",
                 i, wb_valid, op_ready, wb_data);
      end
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    op_valid      = 1'b0;
    op_is_load    = 1'b0;
    op_zero_ext   = 1'b0;
    op_size       = 2'd0;
    op_rd         = 5'd0;
    op_base       = 32'h0;
    op_imm        = 12'h0;
    op_wdata      = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;

    test_reset();
    test_lw();
    test_lb(1'b0, 32'hFFFF_FF80);
    test_lb(1'b1, 32'h0000_0080);
    test_sh();
    test_misalign();
    test_backpressure();
    test_rd_zero();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
